// File: rtl/systolic_feeder.sv
// Operand staging and diagonal skew in front of the PE array.
// Holds one K-deep tile per weight lane (rows) and per activation lane (columns),
// then streams lane n delayed by n cycles with zero padding, plus a single fire pulse.
module systolic_feeder #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned K    = 8,
    localparam int unsigned LMAX   = (ROWS > COLS) ? ROWS : COLS,
    localparam int unsigned LANE_W = (LMAX > 1) ? $clog2(LMAX) : 1,
    localparam int unsigned ADDR_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [LANE_W-1:0] i_wr_lane,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fire,
    output logic [8*ROWS-1:0] o_in_w,
    output logic [8*COLS-1:0] o_in_a
);

    localparam int unsigned T_LAST  = K + LMAX - 2;
    localparam int unsigned DRAIN_N = ROWS + COLS - 1;
    localparam int unsigned CNT_W   = $clog2(T_LAST + DRAIN_N + 2);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_fire;
    logic [8*ROWS-1:0]  r_in_w;
    logic [8*COLS-1:0]  r_in_a;

    logic [7:0]         r_wbuf [ROWS][K];
    logic [7:0]         r_abuf [COLS][K];

    logic               w_wr_ok;
    logic               w_wr_w;
    logic               w_wr_a;
    logic [CNT_W-1:0]   w_t_rd;
    logic [8*ROWS-1:0]  w_nxt_w;
    logic [8*COLS-1:0]  w_nxt_a;

    // Writes are accepted only while not streaming (DONE behaves like IDLE)
    assign w_wr_ok = i_wr_en && (r_state == StIdle || r_state == StDone)
                     && (32'(i_wr_addr) < K);
    assign w_wr_w  = w_wr_ok && !i_wr_sel && (32'(i_wr_lane) < ROWS);
    assign w_wr_a  = w_wr_ok &&  i_wr_sel && (32'(i_wr_lane) < COLS);

    // Tile buffers; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int k = 0; k < int'(K); k++) begin
                if (w_wr_w && 32'(i_wr_lane) == r && 32'(i_wr_addr) == k) begin
                    r_wbuf[r][k] <= i_wr_data;
                end
            end
        end
        for (int c = 0; c < int'(COLS); c++) begin
            for (int k = 0; k < int'(K); k++) begin
                if (w_wr_a && 32'(i_wr_lane) == c && 32'(i_wr_addr) == k) begin
                    r_abuf[c][k] <= i_wr_data;
                end
            end
        end
    end

    // Skewed read of the step being loaded next; forwards a same-edge write so a
    // tile written together with start is seen on the very first step
    always_comb begin : read_mux
        int idx;
        idx     = 0;
        w_t_rd  = (r_state == StStream) ? r_cnt + CNT_W'(1) : '0;
        w_nxt_w = '0;
        w_nxt_a = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            idx = int'(w_t_rd) - r;
            if (idx >= 0 && idx < int'(K)) begin
                w_nxt_w[8*r +: 8] = r_wbuf[r][ADDR_W'(idx)];
                if (w_wr_w && 32'(i_wr_lane) == r && 32'(i_wr_addr) == idx) begin
                    w_nxt_w[8*r +: 8] = i_wr_data;
                end
            end
        end
        for (int c = 0; c < int'(COLS); c++) begin
            idx = int'(w_t_rd) - c;
            if (idx >= 0 && idx < int'(K)) begin
                w_nxt_a[8*c +: 8] = r_abuf[c][ADDR_W'(idx)];
                if (w_wr_a && 32'(i_wr_lane) == c && 32'(i_wr_addr) == idx) begin
                    w_nxt_a[8*c +: 8] = i_wr_data;
                end
            end
        end
    end

    // Sequencer: r_cnt is the stream step on the outputs, then the drain cycle index
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fire  <= 1'b0;
            r_in_w  <= '0;
            r_in_a  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= StStream;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_fire  <= 1'b1;
                        r_in_w  <= w_nxt_w;
                        r_in_a  <= w_nxt_a;
                    end
                end
                StStream: begin
                    r_fire <= 1'b0;
                    if (r_cnt == CNT_W'(T_LAST)) begin
                        r_state <= StDrain;
                        r_cnt   <= '0;
                        r_in_w  <= '0;
                        r_in_a  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_in_w <= w_nxt_w;
                        r_in_a <= w_nxt_a;
                    end
                end
                StDrain: begin
                    if (r_cnt == CNT_W'(DRAIN_N - 1)) begin
                        r_state <= StDone;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    // start is ignored here; it is taken in the following IDLE cycle
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_fire = r_fire;
    assign o_in_w = r_in_w;
    assign o_in_a = r_in_a;

endmodule
